// File: rtl/ycrcb422_unpack.sv
// ycrcb422_unpack
//   Front end of the video path. Locks to the SAV/EAV timing reference codes
//   in an 8-bit BT.656 byte stream and splits the 4:2:2 Cb-Y-Cr-Y sequence
//   into one 4:4:4 (y, cr, cb) triple per luma sample. Each triple carries
//   its column and line coordinates.
//
// Ports
//   clk, rst      : clock and asynchronous active-high reset
//   din, din_en   : BT.656 byte and its qualifier; idle cycles hold all state
//   y, cr, cb     : components of the emitted pixel (hold between strobes)
//   pix_valid     : one-cycle strobe for y/cr/cb/pix_x/line_y
//   pix_x         : column of emitted pixel, 0 at first pixel after SAV
//   line_y        : active line index within the field
//   field, vblank : F and V bits of the last good timing code
//   frame_start   : one-cycle strobe on the first active SAV of a field
//   code_err      : one-cycle strobe for a timing code with bad parity
module ycrcb422_unpack #(
    parameter int XW = 10,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    din,
    input  logic          din_en,
    output logic [7:0]    y,
    output logic [7:0]    cr,
    output logic [7:0]    cb,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [LW-1:0] line_y,
    output logic          field,
    output logic          vblank,
    output logic          frame_start,
    output logic          code_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t        state_r;
    logic [7:0]    hist0_r;   // most recent enabled byte
    logic [7:0]    hist1_r;
    logic [7:0]    hist2_r;   // oldest enabled byte
    logic [1:0]    phase_r;
    logic [7:0]    cb_lat_r;
    logic [7:0]    y0_lat_r;
    logic [7:0]    cr_lat_r;
    logic [XW-1:0] x_cnt_r;
    logic          prev_v_r;  // V bit of the previous good code

    logic          code_good_s;
    logic          code_bad_s;

    // Protection bits P3..P0 that a legal XY byte carries for its F, V, H.
    function automatic logic [3:0] xy_parity(input logic f, input logic v, input logic h);
        xy_parity = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // Classify the current enabled byte as a good or bad XY timing code.
    always_comb begin
        code_good_s = 1'b0;
        code_bad_s  = 1'b0;
        if (din_en && (hist2_r == 8'hFF) && (hist1_r == 8'h00) && (hist0_r == 8'h00)) begin
            if (din[7] && (din[3:0] == xy_parity(din[6], din[5], din[4]))) begin
                code_good_s = 1'b1;
            end else begin
                code_bad_s = 1'b1;
            end
        end else begin
            code_good_s = 1'b0;
            code_bad_s  = 1'b0;
        end
    end

    // Sync tracking, active-video state machine, demux and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hist0_r     <= 8'h00;
            hist1_r     <= 8'h00;
            hist2_r     <= 8'h00;
            phase_r     <= 2'd0;
            cb_lat_r    <= 8'h00;
            y0_lat_r    <= 8'h00;
            cr_lat_r    <= 8'h00;
            x_cnt_r     <= '0;
            prev_v_r    <= 1'b1;
            y           <= 8'h00;
            cr          <= 8'h00;
            cb          <= 8'h00;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            line_y      <= '0;
            field       <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            code_err    <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            code_err    <= 1'b0;
            if (din_en) begin
                hist2_r <= hist1_r;
                hist1_r <= hist0_r;
                hist0_r <= din;
                if (code_bad_s) begin
                    code_err <= 1'b1;
                    state_r  <= ST_IDLE;
                end else if (code_good_s) begin
                    field    <= din[6];
                    vblank   <= din[5];
                    prev_v_r <= din[5];
                    if (din[4]) begin
                        // EAV closes the line; only active lines are counted.
                        state_r <= ST_IDLE;
                        if (!vblank && (line_y != {LW{1'b1}})) begin
                            line_y <= line_y + {{(LW-1){1'b0}}, 1'b1};
                        end
                    end else if (!din[5]) begin
                        state_r <= ST_ACTIVE;
                        phase_r <= 2'd0;
                        x_cnt_r <= '0;
                        if (prev_v_r) begin
                            line_y      <= '0;
                            frame_start <= 1'b1;
                        end
                    end else begin
                        // SAV inside vertical blanking carries no pixels.
                        state_r <= ST_IDLE;
                    end
                end else if (din == 8'hFF) begin
                    // Preamble byte cuts the line short; a partial pair is dropped.
                    state_r <= ST_IDLE;
                end else if (state_r == ST_ACTIVE) begin
                    phase_r <= phase_r + 2'd1;
                    case (phase_r)
                        2'd0: begin
                            cb_lat_r <= din;
                        end
                        2'd1: begin
                            y0_lat_r <= din;
                        end
                        2'd2: begin
                            cr_lat_r  <= din;
                            y         <= y0_lat_r;
                            cr        <= din;
                            cb        <= cb_lat_r;
                            pix_x     <= x_cnt_r;
                            pix_valid <= 1'b1;
                            if (x_cnt_r != {XW{1'b1}}) begin
                                x_cnt_r <= x_cnt_r + {{(XW-1){1'b0}}, 1'b1};
                            end
                        end
                        2'd3: begin
                            y         <= din;
                            cr        <= cr_lat_r;
                            cb        <= cb_lat_r;
                            pix_x     <= x_cnt_r;
                            pix_valid <= 1'b1;
                            if (x_cnt_r != {XW{1'b1}}) begin
                                x_cnt_r <= x_cnt_r + {{(XW-1){1'b0}}, 1'b1};
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ycrcb422_unpack.sv
// Scoreboard bench for ycrcb422_unpack. Stimulus tasks feed bytes to the DUT
// and to a byte-level reference model; the model pushes expected pixels and
// events into queues that a negedge monitor pops whenever the DUT strobes.
module tb_ycrcb422_unpack;

    localparam int XW_T = 4;
    localparam int LW_T = 3;
    localparam int XMAX = (1 << XW_T) - 1;
    localparam int LMAX = (1 << LW_T) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      din;
    logic            din_en;
    logic [7:0]      y, cr, cb;
    logic            pix_valid;
    logic [XW_T-1:0] pix_x;
    logic [LW_T-1:0] line_y;
    logic            field, vblank, frame_start, code_err;

    ycrcb422_unpack #(.XW(XW_T), .LW(LW_T)) dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en),
        .y(y), .cr(cr), .cb(cb), .pix_valid(pix_valid),
        .pix_x(pix_x), .line_y(line_y), .field(field), .vblank(vblank),
        .frame_start(frame_start), .code_err(code_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int py; int pcr; int pcb; int px; int pline;
    } pix_t;
    typedef struct {
        int f; int v; int l;
    } fs_t;

    int total = 0;
    int bad   = 0;
    int pix_seen = 0;
    int fs_seen  = 0;
    int err_seen = 0;
    int err_pend = 0;

    pix_t pix_q[$];
    fs_t  fs_q[$];

    // reference model state
    logic [7:0] hist[$];
    logic [7:0] line_q[$];
    bit m_active;
    int m_x, m_line, m_field, m_vblank, m_prevv;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        line_q.delete();
        m_active = 0; m_x = 0; m_line = 0;
        m_field = 0; m_vblank = 0; m_prevv = 1;
    endtask

    task automatic model_emit(input logic [7:0] yy, input logic [7:0] rr, input logic [7:0] bb);
        pix_t p;
        p.py = yy; p.pcr = rr; p.pcb = bb; p.px = m_x; p.pline = m_line;
        pix_q.push_back(p);
        if (m_x < XMAX) m_x++;
    endtask

    // Behavioural model: legal XY codes are the eight table values; pixels are
    // read back from the bytes collected since SAV.
    task automatic model_byte(input logic [7:0] b);
        bit is_code;
        int n;
        fs_t e;
        is_code = (hist.size() == 3) && (hist[0] == 8'hFF) && (hist[1] == 8'h00) && (hist[2] == 8'h00);
        if (is_code) begin
            if (!(b inside {8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1})) begin
                err_pend++;
                m_active = 0;
            end else begin
                if (b[4]) begin
                    if (m_vblank == 0 && m_line < LMAX) m_line++;
                    m_active = 0;
                end else if (!b[5]) begin
                    if (m_prevv != 0) begin
                        m_line = 0;
                        e.f = b[6]; e.v = 0; e.l = 0;
                        fs_q.push_back(e);
                    end
                    m_active = 1;
                    line_q.delete();
                    m_x = 0;
                end else begin
                    m_active = 0;
                end
                m_field = b[6]; m_vblank = b[5]; m_prevv = b[5];
            end
        end else if (b == 8'hFF) begin
            m_active = 0;
        end else if (m_active) begin
            line_q.push_back(b);
            n = line_q.size();
            if (n % 4 == 3) model_emit(line_q[n-2], line_q[n-1], line_q[n-3]);
            else if (n % 4 == 0) model_emit(line_q[n-1], line_q[n-2], line_q[n-4]);
        end
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    // Drive one enabled byte, then 'gap' idle cycles with junk on din.
    task automatic send(input logic [7:0] b, input int gap);
        din = b; din_en = 1'b1;
        model_byte(b);
        @(posedge clk); #1;
        din_en = 1'b0; din = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_code(input logic [7:0] xy, input int gap);
        send(8'hFF, gap); send(8'h00, gap); send(8'h00, gap); send(xy, gap);
    endtask

    task automatic send_pair(input int gap);
        send(8'h82, gap); send(8'h48, gap); send(8'hAD, gap); send(8'h49, gap);
    endtask

    // Let the last strobe reach the monitor, then check nothing is pending.
    task automatic drain(input string tag);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({tag, "_pix_q_empty"}, pix_q.size(), 0);
        chk({tag, "_fs_q_empty"}, fs_q.size(), 0);
        chk({tag, "_err_pending"}, err_pend, 0);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_field"}, int'(field), m_field);
        chk({tag, "_vblank"}, int'(vblank), m_vblank);
        chk({tag, "_line_y"}, int'(line_y), m_line);
    endtask

    task automatic apply_reset();
        din_en = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1; din = 8'($urandom); din_en = 1'($urandom);
        #2;
        chk("rst_y", int'(y), 0);
        chk("rst_cr", int'(cr), 0);
        chk("rst_cb", int'(cb), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_line_y", int'(line_y), 0);
        chk("rst_field", int'(field), 0);
        chk("rst_vblank", int'(vblank), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_code_err", int'(code_err), 0);
        @(posedge clk); #1;
        rst = 1'b0; din_en = 1'b0;
        model_reset();
        pix_q.delete(); fs_q.delete(); err_pend = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid) begin
                pix_t p;
                pix_seen++;
                chk("pix_expected", int'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) begin
                    p = pix_q.pop_front();
                    chk("pix_y", int'(y), p.py);
                    chk("pix_cr", int'(cr), p.pcr);
                    chk("pix_cb", int'(cb), p.pcb);
                    chk("pix_x", int'(pix_x), p.px);
                    chk("pix_line_y", int'(line_y), p.pline);
                end
            end
            if (frame_start) begin
                fs_t e;
                fs_seen++;
                chk("fs_expected", int'(fs_q.size() > 0), 1);
                if (fs_q.size() > 0) begin
                    e = fs_q.pop_front();
                    chk("fs_field", int'(field), e.f);
                    chk("fs_vblank", int'(vblank), e.v);
                    chk("fs_line_y", int'(line_y), e.l);
                end
            end
            if (code_err) begin
                err_seen++;
                chk("code_err_expected", int'(err_pend > 0), 1);
                if (err_pend > 0) err_pend--;
            end
        end
    end

    initial begin
        int p0, f0, e0;
        rst = 1'b1; din = 8'h00; din_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // filler after reset: no pixels
        p0 = pix_seen;
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 8'h10 : 8'h80, 0);
        drain("filler");
        chk("filler_no_pix", pix_seen - p0, 0);

        // basic pair
        p0 = pix_seen; f0 = fs_seen;
        send_code(8'h80, 0);
        send_pair(0);
        drain("basic");
        chk("basic_pix_count", pix_seen - p0, 2);
        chk("basic_fs_count", fs_seen - f0, 1);
        chk("basic_last_y", int'(y), 73);
        chk("basic_last_x", int'(pix_x), 1);
        chk_status("basic");

        // EAV termination
        p0 = pix_seen;
        send_code(8'h9D, 0);
        send_pair(0);
        drain("eav");
        chk("eav_no_pix", pix_seen - p0, 0);
        chk("eav_line_y", int'(line_y), 1);
        chk("eav_vblank", int'(vblank), 0);

        // parity error
        p0 = pix_seen; e0 = err_seen;
        send_code(8'h81, 0);
        send_pair(0);
        drain("parity");
        chk("parity_err_count", err_seen - e0, 1);
        chk("parity_no_pix", pix_seen - p0, 0);

        // gapped input
        p0 = pix_seen;
        send_code(8'h80, 2);
        send_pair(2);
        drain("gapped");
        chk("gapped_pix_count", pix_seen - p0, 2);
        chk("gapped_last_cr", int'(cr), 173);

        // field sequencing
        f0 = fs_seen;
        send_code(8'hB6, 0);
        send_code(8'hAB, 0);
        chk("fs_seq_vblank_hi", int'(vblank), 1);
        send_code(8'hC7, 0);
        send_pair(0);
        drain("fieldseq");
        chk("fs_seq_field", int'(field), 1);
        chk("fs_seq_vblank", int'(vblank), 0);
        chk("fs_seq_line", int'(line_y), 0);
        chk("fs_seq_fs_count", fs_seen - f0, 1);

        // reset mid-pair: nothing until the next SAV
        send_code(8'h80, 0);
        send(8'h82, 0); send(8'h48, 0);
        apply_reset();
        p0 = pix_seen;
        send(8'hAD, 0); send(8'h49, 0); send_pair(0);
        drain("midrst");
        chk("midrst_no_pix", pix_seen - p0, 0);
        send_code(8'h80, 0);
        send_pair(0);
        drain("midrst_resume");
        chk("midrst_resume_pix", pix_seen - p0, 2);

        // randomized stream
        for (int it = 0; it < 400; it++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 35) begin
                logic [7:0] xy;
                int k;
                k = $urandom_range(0, 9);
                case (k)
                    0, 1, 2: xy = 8'h80;
                    3, 4:    xy = 8'hC7;
                    5:       xy = 8'h9D;
                    6:       xy = 8'hDA;
                    7:       xy = ($urandom_range(0, 1) == 0) ? 8'hAB : 8'hB6;
                    8:       xy = ($urandom_range(0, 1) == 0) ? 8'hEC : 8'hF1;
                    default: xy = 8'($urandom);
                endcase
                send_code(xy, $urandom_range(0, 1));
            end else if (sel < 97) begin
                int n;
                n = $urandom_range(1, 12);
                for (int j = 0; j < n; j++) begin
                    logic [7:0] b;
                    b = ($urandom_range(0, 24) == 0) ? 8'hFF : 8'($urandom);
                    send(b, $urandom_range(0, 2));
                end
            end else begin
                apply_reset();
            end
        end
        drain("random");
        chk_status("random_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
